tick_burst_gen: RTL and testbench

Downstream consumer of the clock divider output. Treats clk_div as data synchronous to CLK and detects its rising edges as "ticks". On request it emits a programmable burst of pulses, with high and low widths measured in ticks, using a start/busy/done handshake. Used to derive timed control strobes from the selected divided rate without clocking logic on clk_div.

---
 rtl/tick_burst_gen_if.sv | 26 ++
 rtl/tick_burst_gen.sv | 177 +++++++++++++++++
 tb/tb_tick_burst_gen.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_burst_gen_if.sv
// Handshake and configuration bundle for tick_burst_gen.
// The master side requests bursts and reads status; the slave side is the generator.
interface tick_burst_gen_if #(
  parameter int CNT_W = 8,
  parameter int TW    = 4
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] burst_len;
  logic [TW-1:0]    high_ticks;
  logic [TW-1:0]    low_ticks;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulse_cnt;

  modport master (
    output start, abort, burst_len, high_ticks, low_ticks,
    input  pulse_out, busy, done, pulse_cnt
  );

  modport slave (
    input  start, abort, burst_len, high_ticks, low_ticks,
    output pulse_out, busy, done, pulse_cnt
  );
endinterface

// File: rtl/tick_burst_gen.sv
// Burst generator timed by rising edges ("ticks") of a divided clock that is
// sampled as ordinary data in the CLK domain. Emits burst_len pulses whose high
// and low widths are counted in ticks, with a start/busy/done handshake and a
// synchronous abort.
module tick_burst_gen #(
  parameter int CNT_W = 8,
  parameter int TW    = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            clk_div,
  tick_burst_gen_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic             clk_div_d_reg;
  logic [CNT_W-1:0] len_reg, len_next;
  logic [TW-1:0]    hi_reg, hi_next;
  logic [TW-1:0]    lo_reg, lo_next;
  logic [TW-1:0]    tcnt_reg, tcnt_next;
  logic             pulse_reg, pulse_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic             tick;
  logic [CNT_W-1:0] cnt_inc;
  logic [TW-1:0]    hi_sel;
  logic [TW-1:0]    lo_sel;
  logic             tcnt_last;

  // A tick is a 0->1 transition of clk_div between consecutive CLK samples.
  assign tick      = clk_div & ~clk_div_d_reg;
  assign cnt_inc   = cnt_reg + CNT_W'(1);
  // Zero widths would stall the counter, so they are promoted to one tick.
  assign hi_sel    = (bus.high_ticks == '0) ? TW'(1) : bus.high_ticks;
  assign lo_sel    = (bus.low_ticks == '0) ? TW'(1) : bus.low_ticks;
  // The counter is never below 1 in HIGH/LOW; <= keeps it from wrapping regardless.
  assign tcnt_last = (tcnt_reg <= TW'(1));

  // Next-state and registered-output logic for the burst sequencer.
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    tcnt_next  = tcnt_reg;
    pulse_next = pulse_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    cnt_next   = cnt_reg;

    unique case (state_reg)
      S_IDLE: begin
        // Ticks are ignored here, so a tick coincident with acceptance never
        // launches the first pulse. Abort has no meaning while idle.
        if (bus.start) begin
          cnt_next = '0;
          if (bus.burst_len != '0) begin
            len_next   = bus.burst_len;
            hi_next    = hi_sel;
            lo_next    = lo_sel;
            busy_next  = 1'b1;
            state_next = S_ARM;
          end else begin
            done_next = 1'b1;
          end
        end
      end

      S_ARM: begin
        if (bus.abort) begin
          pulse_next = 1'b0;
          busy_next  = 1'b0;
          state_next = S_IDLE;
        end else if (tick) begin
          pulse_next = 1'b1;
          tcnt_next  = hi_reg;
          state_next = S_HIGH;
        end
      end

      S_HIGH: begin
        if (bus.abort) begin
          pulse_next = 1'b0;
          busy_next  = 1'b0;
          state_next = S_IDLE;
        end else if (tick) begin
          if (tcnt_last) begin
            pulse_next = 1'b0;
            cnt_next   = cnt_inc;
            tcnt_next  = '0;
            if (cnt_inc == len_reg) begin
              // done and the busy drop are registered on the same edge.
              busy_next  = 1'b0;
              done_next  = 1'b1;
              state_next = S_DONE;
            end else begin
              tcnt_next  = lo_reg;
              state_next = S_LOW;
            end
          end else begin
            tcnt_next = tcnt_reg - TW'(1);
          end
        end
      end

      S_LOW: begin
        if (bus.abort) begin
          pulse_next = 1'b0;
          busy_next  = 1'b0;
          state_next = S_IDLE;
        end else if (tick) begin
          if (tcnt_last) begin
            pulse_next = 1'b1;
            tcnt_next  = hi_reg;
            state_next = S_HIGH;
          end else begin
            tcnt_next = tcnt_reg - TW'(1);
          end
        end
      end

      S_DONE: begin
        // Single-cycle completion state; start and abort are not looked at.
        state_next = S_IDLE;
      end

      default: begin
        pulse_next = 1'b0;
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  // State, edge-detect history and output registers with async active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg     <= S_IDLE;
      clk_div_d_reg <= 1'b0;
      len_reg       <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      tcnt_reg      <= '0;
      pulse_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      clk_div_d_reg <= clk_div;
      len_reg       <= len_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      tcnt_reg      <= tcnt_next;
      pulse_reg     <= pulse_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      cnt_reg       <= cnt_next;
    end
  end

  assign bus.pulse_out = pulse_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.pulse_cnt = cnt_reg;

endmodule

// File: tb/tb_tick_burst_gen.sv
// Bench for tick_burst_gen: a tick-counting reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_tick_burst_gen;
  localparam int CNT_W = 8;
  localparam int TW    = 4;

  logic CLK     = 1'b0;
  logic RST     = 1'b0;
  logic clk_div = 1'b0;

  tick_burst_gen_if #(.CNT_W(CNT_W), .TW(TW)) bus ();

  tick_burst_gen #(.CNT_W(CNT_W), .TW(TW)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .clk_div (clk_div),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
    end
  endtask

  // clk_div source: divide-by-div_n square wave, or static hold_val when div_n < 2.
  int   div_n    = 2;
  int   div_cnt  = 0;
  logic hold_val = 1'b0;
  always @(posedge CLK) begin
    #1;
    if (div_n < 2) begin
      clk_div = hold_val;
    end else begin
      div_cnt = (div_cnt + 1 >= div_n) ? 0 : div_cnt + 1;
      clk_div = (div_cnt < div_n / 2);
    end
  end

  // Reference model: once a burst is accepted, the k-th tick afterwards fixes
  // the outputs arithmetically from k, hi, lo and len.
  logic m_prev   = 1'b0;
  bit   m_active = 0;
  bit   m_indone = 0;
  int   m_ticks  = 0;
  int   m_len    = 0;
  int   m_hi     = 0;
  int   m_lo     = 0;
  logic m_pulse  = 1'b0;
  logic m_busy   = 1'b0;
  logic m_done   = 1'b0;
  int   m_cnt    = 0;

  always @(posedge CLK or negedge RST) begin
    bit tk;
    int period;
    int u;
    if (!RST) begin
      m_prev = 1'b0; m_active = 0; m_indone = 0; m_ticks = 0;
      m_pulse = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
    end else begin
      tk     = clk_div && !m_prev;
      m_prev = clk_div;
      m_done = 1'b0;
      if (m_indone) begin
        m_indone = 0;
      end else if (!m_active) begin
        if (bus.start) begin
          m_cnt = 0;
          if (bus.burst_len == 0) begin
            m_done = 1'b1;
          end else begin
            m_active = 1;
            m_ticks  = 0;
            m_len    = int'(bus.burst_len);
            m_hi     = (bus.high_ticks == 0) ? 1 : int'(bus.high_ticks);
            m_lo     = (bus.low_ticks == 0) ? 1 : int'(bus.low_ticks);
            m_busy   = 1'b1;
          end
        end
      end else if (bus.abort) begin
        m_active = 0;
        m_busy   = 1'b0;
        m_pulse  = 1'b0;
      end else if (tk) begin
        m_ticks++;
        period = m_hi + m_lo;
        u      = m_ticks - 1;
        if (m_ticks == (m_len - 1) * period + m_hi + 1) begin
          m_pulse  = 1'b0;
          m_cnt    = m_len;
          m_busy   = 1'b0;
          m_done   = 1'b1;
          m_active = 0;
          m_indone = 1;
        end else begin
          m_pulse = ((u % period) < m_hi);
          m_cnt   = u / period + (((u % period) >= m_hi) ? 1 : 0);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    chk("cyc_pulse_out", 32'(bus.pulse_out), 32'(m_pulse));
    chk("cyc_busy",      32'(bus.busy),      32'(m_busy));
    chk("cyc_done",      32'(bus.done),      32'(m_done));
    chk("cyc_pulse_cnt", 32'(bus.pulse_cnt), 32'(m_cnt));
  end

  // Width monitor: records lengths of pulse_out high runs and of low runs between highs.
  int   hq[$];
  int   lq[$];
  int   hrun = 0;
  int   lrun = 0;
  bit   seen_high = 0;
  logic last_p = 1'b0;
  int   done_total = 0;
  always @(negedge CLK) begin
    if (bus.done === 1'b1) done_total++;
    if (bus.pulse_out === 1'b1) begin
      if (!last_p) begin
        if (seen_high) lq.push_back(lrun);
        hrun = 0;
      end
      hrun++;
    end else begin
      if (last_p) begin
        hq.push_back(hrun);
        seen_high = 1;
        lrun = 0;
      end
      lrun++;
    end
    last_p = (bus.pulse_out === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic go(input int len, input int hi, input int lo);
    bus.burst_len  = CNT_W'(len);
    bus.high_ticks = TW'(hi);
    bus.low_ticks  = TW'(lo);
    bus.start      = 1'b1;
    step(1);
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    bit ok;
    ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge CLK);
      if (bus.done === 1'b1) ok = 1;
    end
    chk("done_seen", 32'(ok), 32'd1);
    step(1);
  endtask

  task automatic check_widths(input int h0, input int n, input int hw, input int lw);
    chk("num_pulses", 32'(hq.size() - h0), 32'(n));
    for (int i = 0; i < n && h0 + i < hq.size(); i++)
      chk("high_width", 32'(hq[h0 + i]), 32'(hw));
    if (lq.size() >= n - 1) begin
      for (int i = 1; i < n; i++)
        chk("low_width", 32'(lq[lq.size() - n + i]), 32'(lw));
    end else begin
      chk("low_runs", 32'(lq.size()), 32'(n - 1));
    end
  endtask

  initial begin
    int h0, d0, n;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.burst_len = '0; bus.high_ticks = '0; bus.low_ticks = '0;

    // Reset held with clk_div toggling.
    div_n = 2;
    step(6);
    @(negedge CLK);
    chk("rst_pulse_out", 32'(bus.pulse_out), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_done",      32'(bus.done),      32'd0);
    chk("rst_pulse_cnt", 32'(bus.pulse_cnt), 32'd0);
    step(1);
    RST = 1'b1;
    step(10);
    chk("idle_pulse_out", 32'(bus.pulse_out), 32'd0);
    $display("txn reset: outputs low, idle after release");

    // Basic burst: divide-by-4, len 3, hi 2, lo 1.
    div_n = 4;
    h0 = hq.size(); d0 = done_total;
    go(3, 2, 1);
    wait_done(400);
    check_widths(h0, 3, 8, 4);
    chk("basic_cnt",  32'(bus.pulse_cnt), 32'd3);
    chk("basic_done", 32'(done_total - d0), 32'd1);
    $display("txn basic: len=3 hi=2 lo=1 cnt=%0d", bus.pulse_cnt);

    // burst_len = 0: immediate done, no busy.
    go(0, 2, 2);
    @(negedge CLK);
    chk("len0_done", 32'(bus.done), 32'd1);
    chk("len0_busy", 32'(bus.busy), 32'd0);
    step(1);
    @(negedge CLK);
    chk("len0_done_clr", 32'(bus.done), 32'd0);
    step(1);
    $display("txn len0: single done, busy low");

    // Zero widths promoted to one tick at divide-by-2.
    div_n = 2;
    step(4);
    h0 = hq.size();
    go(2, 0, 0);
    wait_done(200);
    check_widths(h0, 2, 2, 2);
    chk("zero_cnt", 32'(bus.pulse_cnt), 32'd2);
    $display("txn zero-widths: len=2 cnt=%0d", bus.pulse_cnt);

    // Abort during the second high phase.
    div_n = 4;
    step(4);
    d0 = done_total;
    go(5, 3, 2);
    n = 0;
    while (!(bus.pulse_cnt == 1 && bus.pulse_out === 1'b1) && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("abort_reach_high2", 32'(n < 400), 32'd1);
    step(1);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    @(negedge CLK);
    chk("abort_pulse_out", 32'(bus.pulse_out), 32'd0);
    chk("abort_busy",      32'(bus.busy),      32'd0);
    step(20);
    chk("abort_no_done", 32'(done_total - d0), 32'd0);
    chk("abort_cnt",     32'(bus.pulse_cnt),   32'd1);
    go(5, 3, 2);
    wait_done(800);
    chk("after_abort_cnt", 32'(bus.pulse_cnt), 32'd5);
    $display("txn abort: partial=1 then full burst cnt=%0d", bus.pulse_cnt);

    // Start and abort together in IDLE: start wins.
    bus.abort = 1'b1;
    go(1, 1, 1);
    bus.abort = 1'b0;
    @(negedge CLK);
    chk("start_abort_busy", 32'(bus.busy), 32'd1);
    wait_done(100);
    $display("txn start+abort in idle: accepted");

    // Busy protection, with acceptance on a tick cycle.
    n = 0;
    while (!(clk_div && !m_prev) && n < 20) begin
      step(1);
      n++;
    end
    h0 = hq.size();
    bus.burst_len = 8'd3; bus.high_ticks = 4'd1; bus.low_ticks = 4'd1;
    bus.start = 1'b1;
    step(1);
    bus.burst_len = 8'd9;
    n = 0;
    @(negedge CLK);
    while (bus.pulse_out !== 1'b1 && n < 20) begin
      n++;
      @(negedge CLK);
    end
    chk("arm_ignores_accept_tick", 32'(n), 32'd4);
    step(4);
    bus.start = 1'b0;
    wait_done(200);
    chk("protect_cnt", 32'(bus.pulse_cnt), 32'd3);
    check_widths(h0, 3, 4, 4);
    $display("txn busy-protect: len kept at 3, cnt=%0d", bus.pulse_cnt);

    // Asynchronous reset during LOW.
    step(4);
    d0 = done_total;
    go(3, 2, 2);
    n = 0;
    while (!(bus.pulse_cnt == 1 && bus.pulse_out === 1'b0 && bus.busy === 1'b1) && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("rst_reach_low", 32'(n < 400), 32'd1);
    step(1);
    RST = 1'b0;
    #1;
    chk("arst_pulse_out", 32'(bus.pulse_out), 32'd0);
    chk("arst_busy",      32'(bus.busy),      32'd0);
    chk("arst_done",      32'(bus.done),      32'd0);
    chk("arst_pulse_cnt", 32'(bus.pulse_cnt), 32'd0);
    step(3);
    RST = 1'b1;
    step(3);
    chk("arst_no_done", 32'(done_total - d0), 32'd0);
    $display("txn async reset mid-burst: outputs cleared, no done");

    // Static clk_div: waits in ARM until abort.
    div_n = 0; hold_val = 1'b0;
    step(2);
    go(2, 1, 1);
    step(30);
    chk("static_busy",  32'(bus.busy),      32'd1);
    chk("static_pulse", 32'(bus.pulse_out), 32'd0);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    @(negedge CLK);
    chk("static_abort_busy", 32'(bus.busy), 32'd0);
    step(1);
    $display("txn static clk_div: held busy, abort released");

    // Random traffic against the model.
    for (int blk = 0; blk < 6; blk++) begin
      div_n = $urandom_range(2, 5);
      d0 = done_total;
      for (int c = 0; c < 500; c++) begin
        bus.start      = ($urandom_range(0, 15) == 0);
        bus.burst_len  = CNT_W'($urandom_range(0, 5));
        bus.high_ticks = TW'($urandom_range(0, 4));
        bus.low_ticks  = TW'($urandom_range(0, 4));
        bus.abort      = ($urandom_range(0, 299) == 0);
        step(1);
      end
      $display("txn random block %0d: div=%0d dones=%0d", blk, div_n, done_total - d0);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
